// File: rtl/hazard_scan_pkg.sv
// Shared definitions for the hazard scanner: hazard codes, FSM state type,
// instruction field extraction and emit-order helpers.
package hazard_pkg;

  localparam logic [1:0] HZ_RAW = 2'b10;
  localparam logic [1:0] HZ_WAR = 2'b01;
  localparam logic [1:0] HZ_WAW = 2'b11;

  // Widest register index the field helpers handle; instructions are
  // zero-extended to IW_MAX bits before extraction.
  localparam int RW_MAX = 8;
  localparam int IW_MAX = 3 * RW_MAX;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Extract one RW-wide field; slot 2 = rd, 1 = rs1, 0 = rs2.
  function automatic logic [RW_MAX-1:0] field_of(input logic [IW_MAX-1:0] instr,
                                                  input int rw, input int slot);
    logic [IW_MAX-1:0] shifted;
    logic [IW_MAX-1:0] keep;
    shifted = instr >> (slot * rw);
    keep    = (IW_MAX'(1'b1) << rw) - IW_MAX'(1'b1);
    return RW_MAX'(shifted & keep);
  endfunction

  function automatic logic [RW_MAX-1:0] rd_of(input logic [IW_MAX-1:0] instr, input int rw);
    return field_of(instr, rw, 2);
  endfunction

  function automatic logic [RW_MAX-1:0] rs1_of(input logic [IW_MAX-1:0] instr, input int rw);
    return field_of(instr, rw, 1);
  endfunction

  function automatic logic [RW_MAX-1:0] rs2_of(input logic [IW_MAX-1:0] instr, input int rw);
    return field_of(instr, rw, 0);
  endfunction

  // Mask layout is {RAW, WAR, WAW}; records leave in that priority order.
  function automatic logic [1:0] first_kind(input logic [2:0] mask);
    logic [1:0] kind;
    if (mask[2]) begin
      kind = HZ_RAW;
    end else if (mask[1]) begin
      kind = HZ_WAR;
    end else if (mask[0]) begin
      kind = HZ_WAW;
    end else begin
      kind = 2'b00;
    end
    return kind;
  endfunction

  function automatic logic [2:0] kind_bit(input logic [1:0] kind);
    logic [2:0] bit_sel;
    case (kind)
      HZ_RAW:  bit_sel = 3'b100;
      HZ_WAR:  bit_sel = 3'b010;
      HZ_WAW:  bit_sel = 3'b001;
      default: bit_sel = 3'b000;
    endcase
    return bit_sel;
  endfunction

endpackage

// File: rtl/hazard_scan_if.sv
// Load-beat and hazard-record handshakes of the hazard scanner.
// slave = scanner side, master = producer/consumer side.
interface hazard_scan_if #(
  parameter int RW    = 3,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic            in_valid;
  logic            in_ready;
  logic [3*RW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_kind;
  logic [AW-1:0]   out_i;
  logic [AW-1:0]   out_j;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_kind, out_i, out_j
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_kind, out_i, out_j
  );
endinterface

// File: rtl/hazard_scan_pair_cmp.sv
// Combinational hazard test for one (older, younger) instruction pair.
// mask = {RAW, WAR, WAW}.
module hazard_pair_cmp
  import hazard_pkg::*;
#(
  parameter int RW        = 3,
  parameter int IGNORE_R0 = 0
) (
  input  logic [3*RW-1:0] older,
  input  logic [3*RW-1:0] younger,
  output logic [2:0]      mask
);

  logic [RW-1:0] rd_o, rs1_o, rs2_o;
  logic [RW-1:0] rd_y, rs1_y, rs2_y;
  logic          raw, war, waw;

  // Register-index equality; index 0 is a non-participant when IGNORE_R0 is set.
  function automatic logic reg_match(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic hit;
    if ((IGNORE_R0 != 0) && ((a == {RW{1'b0}}) || (b == {RW{1'b0}}))) begin
      hit = 1'b0;
    end else begin
      hit = (a == b);
    end
    return hit;
  endfunction

  // Split both instructions into fields and evaluate the three hazard kinds.
  always_comb begin
    rd_o  = RW'(rd_of(IW_MAX'(older), RW));
    rs1_o = RW'(rs1_of(IW_MAX'(older), RW));
    rs2_o = RW'(rs2_of(IW_MAX'(older), RW));
    rd_y  = RW'(rd_of(IW_MAX'(younger), RW));
    rs1_y = RW'(rs1_of(IW_MAX'(younger), RW));
    rs2_y = RW'(rs2_of(IW_MAX'(younger), RW));
    raw   = reg_match(rd_o, rs1_y) || reg_match(rd_o, rs2_y);
    war   = reg_match(rd_y, rs1_o) || reg_match(rd_y, rs2_o);
    waw   = reg_match(rd_o, rd_y);
    mask  = {raw, war, waw};
  end

endmodule

// File: rtl/hazard_scan.sv
// Hazard scanner: loads up to DEPTH instructions, walks every (i,j) pair
// with j-i <= WINDOW one per cycle and emits one record per hazard found.
module hazard_scan
  import hazard_pkg::*;
#(
  parameter int RW        = 3,
  parameter int DEPTH     = 8,
  parameter int WINDOW    = DEPTH - 1,
  parameter int IGNORE_R0 = 0
) (
  input  logic           clk,
  input  logic           rst,
  hazard_scan_if.slave   bus,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [15:0]    hazard_count
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so counts and indices can reach DEPTH itself.
  localparam int CW = AW + 1;

  state_t          state;
  logic [CW-1:0]   fill;
  logic [CW-1:0]   n_instr;
  logic [CW-1:0]   i;
  logic [CW-1:0]   j;
  logic [2:0]      mask;
  logic [3*RW-1:0] mem [DEPTH];

  logic            accept;
  logic            wr_en;
  logic [CW-1:0]   fill_next;
  logic [3*RW-1:0] older;
  logic [3*RW-1:0] younger;
  logic [2:0]      pair_mask;
  logic [2:0]      mask_left;
  logic [CW-1:0]   j_inc;
  logic [CW-1:0]   adv_i;
  logic [CW-1:0]   adv_j;
  logic            adv_done;

  // Load-side bookkeeping: which beats land and where the buffer goes next.
  always_comb begin
    accept    = (state == ST_LOAD) && bus.in_valid && bus.in_ready;
    wr_en     = accept && !rst;
    fill_next = fill + CW'(accept);
  end

  // Instruction buffer: written on every accepted beat, contents never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[fill[AW-1:0]] <= bus.in_data;
    end
  end

  // Current pair operands and the bits still to emit for it.
  always_comb begin
    older     = mem[i[AW-1:0]];
    younger   = mem[j[AW-1:0]];
    mask_left = mask & ~kind_bit(bus.out_kind);
  end

  hazard_pair_cmp #(
    .RW        (RW),
    .IGNORE_R0 (IGNORE_R0)
  ) u_cmp (
    .older   (older),
    .younger (younger),
    .mask    (pair_mask)
  );

  // Next pair: step j inside the window, else restart at (i+1, i+2); done when j runs off.
  always_comb begin
    j_inc = j + CW'(1'b1);
    if ((j_inc < n_instr) && (int'(j_inc - i) <= WINDOW)) begin
      adv_i    = i;
      adv_j    = j_inc;
      adv_done = 1'b0;
    end else begin
      adv_i    = i + CW'(1'b1);
      adv_j    = i + CW'(2'd2);
      adv_done = ((i + CW'(2'd2)) >= n_instr);
    end
  end

  // Control FSM: load, pair scan, record emission, completion; drives all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_LOAD;
      fill          <= {CW{1'b0}};
      n_instr       <= {CW{1'b0}};
      i             <= {CW{1'b0}};
      j             <= CW'(1'b1);
      mask          <= 3'b000;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_kind  <= 2'b00;
      bus.out_i     <= {AW{1'b0}};
      bus.out_j     <= {AW{1'b0}};
      done          <= 1'b0;
      busy          <= 1'b0;
      hazard_count  <= 16'h0000;
    end else begin
      case (state)
        ST_LOAD: begin
          fill <= fill_next;
          if (start) begin
            n_instr      <= fill_next;
            i            <= {CW{1'b0}};
            j            <= CW'(1'b1);
            bus.in_ready <= 1'b0;
            if (fill_next >= CW'(2'd2)) begin
              state <= ST_SCAN;
              busy  <= 1'b1;
            end else begin
              state        <= ST_DONE;
              done         <= 1'b1;
              hazard_count <= 16'h0000;
            end
          end else begin
            bus.in_ready <= (fill_next < CW'(DEPTH));
          end
        end
        ST_SCAN: begin
          if (pair_mask != 3'b000) begin
            mask          <= pair_mask;
            state         <= ST_EMIT;
            bus.out_valid <= 1'b1;
            bus.out_kind  <= first_kind(pair_mask);
            bus.out_i     <= i[AW-1:0];
            bus.out_j     <= j[AW-1:0];
          end else if (adv_done) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i <= adv_i;
            j <= adv_j;
          end
        end
        ST_EMIT: begin
          if (bus.out_valid && bus.out_ready) begin
            if (hazard_count != 16'hFFFF) begin
              hazard_count <= hazard_count + 16'h0001;
            end
            if (mask_left != 3'b000) begin
              mask         <= mask_left;
              bus.out_kind <= first_kind(mask_left);
            end else begin
              mask          <= 3'b000;
              bus.out_valid <= 1'b0;
              if (adv_done) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_SCAN;
                i     <= adv_i;
                j     <= adv_j;
              end
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state        <= ST_LOAD;
            fill         <= {CW{1'b0}};
            hazard_count <= 16'h0000;
            done         <= 1'b0;
            bus.in_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scan.sv
// Testbench for hazard_scan. Two instances share stimulus:
//   dut_a: IGNORE_R0=0, WINDOW=2      dut_b: IGNORE_R0=1, default WINDOW (7)
// Directed vector table for two-instruction loads plus hand-written
// sequences for stall, start-with-beat, full buffer/window and reset abort.
module tb_hazard_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = 9'd0;
  logic       out_ready = 1'b1;

  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] cnt_a, cnt_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  // 10-unit clock
  always #5 clk = ~clk;

  hazard_scan_if #(.RW(3), .DEPTH(8)) bus_a ();
  hazard_scan_if #(.RW(3), .DEPTH(8)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  hazard_scan #(.RW(3), .DEPTH(8), .WINDOW(2), .IGNORE_R0(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .start(start),
    .busy(busy_a), .done(done_a), .hazard_count(cnt_a)
  );

  hazard_scan #(.RW(3), .DEPTH(8), .IGNORE_R0(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .start(start),
    .busy(busy_b), .done(done_b), .hazard_count(cnt_b)
  );

  // Record every completed hazard handshake as {kind, i, j}
  always @(negedge clk) begin
    if (!rst && bus_a.out_valid && bus_a.out_ready)
      qa.push_back({bus_a.out_kind, bus_a.out_i, bus_a.out_j});
    if (!rst && bus_b.out_valid && bus_b.out_ready)
      qb.push_back({bus_b.out_kind, bus_b.out_i, bus_b.out_j});
  end

  typedef struct {
    logic [8:0] older;
    logic [8:0] younger;
    int         na;
    logic [5:0] ka;
    int         nb;
    logic [5:0] kb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [8:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done_a && done_b) seen = 1'b1;
    end
    check("done_within_budget", 32'(seen), 32'd1);
    tick();
  endtask

  task automatic wait_valid_a(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (bus_a.out_valid) seen = 1'b1;
    end
    check("valid_within_budget", 32'(seen), 32'd1);
  endtask

  function automatic logic [7:0] rec_at(input logic [7:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    else return 8'hFF;
  endfunction

  task automatic check_recs(input string tag, input logic [7:0] q[$], input int n,
                            input logic [5:0] kinds, input logic [15:0] cnt);
    check({tag, "_nrec"}, 32'(q.size()), 32'(n));
    check({tag, "_count"}, 32'(cnt), 32'(n));
    for (int k = 0; k < n; k++) begin
      logic [7:0] want;
      want = {kinds[5-2*k -: 2], 3'd0, 3'd1};
      check($sformatf("%s_rec%0d", tag, k), 32'(rec_at(q, k)), 32'(want));
    end
  endtask

  initial begin
    vecs[0] = '{9'b001_010_011, 9'b100_001_101, 1, 6'b10_00_00, 1, 6'b10_00_00};
    vecs[1] = '{9'b001_011_100, 9'b011_101_110, 1, 6'b01_00_00, 1, 6'b01_00_00};
    vecs[2] = '{9'b010_011_100, 9'b010_101_110, 1, 6'b11_00_00, 1, 6'b11_00_00};
    vecs[3] = '{9'b000_000_000, 9'b000_000_000, 3, 6'b10_01_11, 0, 6'b00_00_00};
    vecs[4] = '{9'b001_010_011, 9'b100_101_110, 0, 6'b00_00_00, 0, 6'b00_00_00};
    vecs[5] = '{9'b000_001_010, 9'b011_000_100, 1, 6'b10_00_00, 0, 6'b00_00_00};
    vecs[6] = '{9'b011_001_010, 9'b001_011_011, 2, 6'b10_01_00, 2, 6'b10_01_00};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_kind", 32'(bus_a.out_kind), 32'd0);
    check("rst_out_ij", 32'({bus_a.out_i, bus_a.out_j}), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_b_in_ready", 32'(bus_b.in_ready), 32'd1);
    tick();

    // Two-instruction vectors
    for (int v = 0; v < 7; v++) begin
      qa.delete();
      qb.delete();
      load_beat(vecs[v].older);
      load_beat(vecs[v].younger);
      pulse_start();
      wait_done(40);
      check_recs($sformatf("vec%0d_a", v), qa, vecs[v].na, vecs[v].ka, cnt_a);
      check_recs($sformatf("vec%0d_b", v), qb, vecs[v].nb, vecs[v].kb, cnt_b);
      pulse_start();
    end
    @(negedge clk);
    check("rearm_done", 32'(done_a), 32'd0);
    check("rearm_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("rearm_count", 32'(cnt_a), 32'd0);
    tick();

    // Start with an empty buffer goes straight to DONE
    pulse_start();
    @(negedge clk);
    check("empty_done", 32'(done_a), 32'd1);
    check("empty_busy", 32'(busy_a), 32'd0);
    check("empty_count", 32'(cnt_a), 32'd0);
    check("empty_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    pulse_start();

    // Beat accepted in the start cycle is stored and counted; check latency
    qa.delete();
    qb.delete();
    load_beat(9'b001_010_011);
    in_valid = 1'b1;
    in_data  = 9'b100_001_101;
    start    = 1'b1;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    check("lat_busy_scan", 32'(busy_a), 32'd1);
    check("lat_valid_scan", 32'(bus_a.out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_emit", 32'(bus_a.out_valid), 32'd1);
    check("lat_kind_emit", 32'(bus_a.out_kind), 32'd2);
    tick();
    wait_done(20);
    check_recs("startbeat_a", qa, 1, 6'b10_00_00, cnt_a);
    pulse_start();

    // Stalled consumer: record held stable, then RAW, WAR, WAW in order
    qa.delete();
    qb.delete();
    out_ready = 1'b0;
    load_beat(9'b010_010_000);
    load_beat(9'b010_010_000);
    pulse_start();
    wait_valid_a(10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rec", c),
            32'({bus_a.out_valid, bus_a.out_kind, bus_a.out_i, bus_a.out_j}),
            32'({1'b1, 2'b10, 3'd0, 3'd1}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(20);
    check_recs("stall_a", qa, 3, 6'b10_01_11, cnt_a);
    check_recs("stall_b", qb, 3, 6'b10_01_11, cnt_b);
    pulse_start();

    // Full buffer: 9th beat refused; window 2 gives 13 pairs, window 7 gives 28
    qa.delete();
    qb.delete();
    for (int b = 0; b < 8; b++) load_beat(9'b001_001_001);
    @(negedge clk);
    check("full_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    load_beat(9'b000_000_000);
    pulse_start();
    wait_done(400);
    check("win_count_a", 32'(cnt_a), 32'd39);
    check("win_nrec_a", 32'(qa.size()), 32'd39);
    check("win_first_a", 32'(rec_at(qa, 0)), 32'({2'b10, 3'd0, 3'd1}));
    check("win_last_a", 32'(rec_at(qa, 38)), 32'({2'b11, 3'd6, 3'd7}));
    check("win_count_b", 32'(cnt_b), 32'd84);
    check("win_last_b", 32'(rec_at(qb, 83)), 32'({2'b11, 3'd6, 3'd7}));
    pulse_start();

    // Reset while a record is pending aborts it
    qa.delete();
    qb.delete();
    out_ready = 1'b0;
    load_beat(9'b010_010_000);
    load_beat(9'b010_010_000);
    pulse_start();
    wait_valid_a(10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_count", 32'(cnt_a), 32'd0);
    check("abort_nrec", 32'(qa.size()), 32'd0);
    out_ready = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scan.md
HAZARD_SCAN -- requirements
Module: hazard_scan

Interface
REQ-001 SHALL have parameter RW, default 3: register-index width; an instruction is 3*RW bits, packed as {rd, rs1, rs2}.
REQ-002 SHALL have parameter DEPTH, default 8: instruction buffer entries, power of two, 2..64.
REQ-003 SHALL have parameter WINDOW, default DEPTH-1: maximum pair distance j-i that is checked.
REQ-004 SHALL have parameter IGNORE_R0, default 0: when 1, register index 0 never participates in a hazard.
REQ-005 SHALL have localparam AW = clog2(DEPTH).
REQ-006 clk  in  1  clock; all logic is on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  load beat valid.
REQ-009 in_ready  out  1  buffer accepts a beat.
REQ-010 in_data  in  3*RW  instruction {rd,rs1,rs2}.
REQ-011 start  in  1  single-cycle pulse: begin scan (in LOAD) or rearm (in DONE).
REQ-012 busy  out  1  state is SCAN or EMIT.
REQ-013 out_valid / out_ready  out / in  1 / 1  hazard-record handshake.
REQ-014 out_kind  out  2  hazard code: RAW=2'b10, WAR=2'b01, WAW=2'b11.
REQ-015 out_i, out_j  out  AW each  older and younger instruction index (i<j).
REQ-016 done  out  1  scan complete; held high until rearm.
REQ-017 hazard_count  out  16  records emitted in this scan; saturates at 16'hFFFF.

Function
REQ-018 FSM states SHALL be LOAD, SCAN, EMIT and DONE.
REQ-019 LOAD: in_ready=1 while fill<DEPTH; each in_valid&in_ready beat writes entry[fill] and increments fill.
REQ-020 At fill==DEPTH, in_ready SHALL be 0 and further beats SHALL be ignored.
REQ-021 start in LOAD: N = fill, plus 1 if a beat is accepted in the same cycle (that beat SHALL be stored).
REQ-022 If N>=2, the FSM SHALL go to SCAN with i=0, j=1; otherwise to DONE with hazard_count=0.
REQ-023 SCAN SHALL evaluate one pair (i,j) per cycle, combinationally:
- RAW = rd_i==rs1_j or rd_i==rs2_j
- WAR = rd_j==rs1_i or rd_j==rs2_i
- WAW = rd_i==rd_j
- With IGNORE_R0=1, any comparison involving index 0 is false.
REQ-024 A nonzero hazard mask SHALL latch the mask and move to EMIT; otherwise the pair advances in the same cycle.
REQ-025 EMIT SHALL present one record per set bit, in the order RAW, WAR, WAW.
REQ-026 out_valid SHALL be asserted the cycle after SCAN detects the hazard.
REQ-027 The record SHALL stay stable while out_valid && !out_ready.
REQ-028 Each handshake SHALL clear the emitted bit and increment hazard_count.
REQ-029 After the last bit's handshake, the pair SHALL advance and the FSM SHALL return to SCAN.
REQ-030 Pair advance:
- j+1 if j+1<N and j+1-i<=WINDOW
- else i+1, j=i+2
- if the new j>=N (i.e. i+1 >= N-1), go to DONE.
REQ-031 Throughput SHALL be 1 cycle per hazard-free pair, and 1+k cycles minimum per pair with k hazards.
REQ-032 DONE: done=1 and busy=0; start SHALL clear fill and hazard_count and go to LOAD.
REQ-033 start SHALL be ignored in SCAN and EMIT; in_ready SHALL be 0 outside LOAD.

Reset
REQ-034 rst SHALL force state LOAD, fill=0, i=0, j=1 and mask=0.
REQ-035 rst SHALL force outputs in_ready=1, out_valid=0, out_kind=0, out_i=0, out_j=0, done=0, busy=0, hazard_count=0.
REQ-036 Buffer contents need not reset.
REQ-037 rst mid-SCAN or mid-EMIT SHALL abort, with out_valid low in the next cycle and no partial record completing.

Structure
REQ-038 A shared package hazard_pkg SHALL hold:
- the hazard code constants HZ_RAW, HZ_WAR, HZ_WAW
- the FSM state enum
- field-extract functions for rd/rs1/rs2 given RW.
REQ-039 The pair comparator SHALL be a sub-module hazard_pair_cmp (params RW, IGNORE_R0; in: two instructions; out: 3-bit mask).

Verification
REQ-040 RW=3: load 001_010_011 and 100_001_101, then start -> one record (kind 10, i=0, j=1), done, hazard_count=1.
REQ-041 Load 001_011_100 and 011_101_110 -> one WAR record (01,0,1).
REQ-042 Load 010_101_110 after 010_011_100 -> one WAW record (11,0,1).
REQ-043 Load 010_010_000 twice, with out_ready held low 5 cycles -> records 10, 01, 11 in order, each stable while stalled, count=3.
REQ-044 Load 000_000_000 twice -> IGNORE_R0=1 gives done with count=0; IGNORE_R0=0 gives 3 records.
REQ-045 DEPTH=8, WINDOW=2, eight copies of 001_001_001 -> 13 pairs x 3 = 39 records, count=39.
REQ-046 A 9th beat is refused (in_ready=0).
REQ-047 rst during EMIT -> out_valid=0 and in_ready=1 next cycle.
